// File: rtl/poly_synth_tdm.sv
// Polyphonic oscillator bank: one shared phase/envelope datapath is stepped across
// every voice once per sample tick, and the voices are summed into one saturated sample.
module poly_synth_tdm #(
  parameter int NUM_VOICES = 32,
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 16,
  parameter int ENV_W      = 8,
  parameter int MIX_SHIFT  = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_sample_tick,
  input  logic [NUM_VOICES-1:0]         i_gate,
  input  logic [1:0]                    i_wave,
  input  logic [ENV_W-1:0]              i_atk_rate,
  input  logic [ENV_W-1:0]              i_rel_rate,
  input  logic                          i_step_we,
  input  logic [$clog2(NUM_VOICES)-1:0] i_step_addr,
  input  logic [PHASE_W-1:0]            i_step_data,
  output logic [OUT_W-1:0]              o_audio,
  output logic                          o_valid,
  output logic                          o_busy,
  output logic                          o_clip,
  output logic                          o_overrun
);
  localparam int VW     = $clog2(NUM_VOICES);
  localparam int ACC_W  = OUT_W + VW + 1;
  localparam int PROD_W = OUT_W + ENV_W + 1;
  localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] SQ_AMP  = {1'b0, {(OUT_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_e;
  state_e state_q, state_d;

  logic [PHASE_W-1:0]      step_q  [NUM_VOICES];
  logic [PHASE_W-1:0]      phase_q [NUM_VOICES];
  logic [ENV_W-1:0]        env_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate_q;
  logic [1:0]              wave_q;
  logic [ENV_W-1:0]        atk_q, rel_q;
  logic [VW-1:0]           voice_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [OUT_W-1:0]        audio_q;
  logic                    valid_q, clip_q, overrun_q;
  logic                    busy;

  logic                     curGate;
  logic [ENV_W:0]           envSum;
  logic [ENV_W-1:0]         envNew;
  logic [PHASE_W-1:0]       phaseNew;
  logic [OUT_W-1:0]         p, triU;
  logic signed [OUT_W-1:0]  waveVal;
  logic signed [PROD_W-1:0] prod, prodShift;
  logic signed [ACC_W-1:0]  contrib, accNext, mixShift;
  logic [OUT_W-1:0]         mixSat;
  logic                     mixClip;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_sample_tick) state_d = ACCUM;
      ACCUM:   if (voice_q == LAST_VOICE) state_d = OUTPUT;
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // Shared per-voice datapath: envelope, phase, waveform shaping and scaling for voice_q.
  always_comb begin
    curGate = gate_q[voice_q];
    envSum  = {1'b0, env_q[voice_q]} + {1'b0, atk_q};
    if (curGate) envNew = envSum[ENV_W] ? '1 : envSum[ENV_W-1:0];
    else         envNew = (env_q[voice_q] > rel_q) ? env_q[voice_q] - rel_q : '0;
    if (!curGate && envNew == '0) phaseNew = '0;
    else                          phaseNew = phase_q[voice_q] + step_q[voice_q];
    p    = phaseNew[PHASE_W-1 -: OUT_W];
    triU = p[OUT_W-1] ? {~p[OUT_W-2:0], 1'b0} : {p[OUT_W-2:0], 1'b0};
    case (wave_q)
      2'b00:   waveVal = {~p[OUT_W-1], p[OUT_W-2:0]};
      2'b01:   waveVal = p[OUT_W-1] ? -SQ_AMP : SQ_AMP;
      2'b10:   waveVal = {~triU[OUT_W-1], triU[OUT_W-2:0]};
      default: waveVal = '0;
    endcase
    prod      = PROD_W'(waveVal) * PROD_W'($signed({1'b0, envNew}));
    prodShift = prod >>> ENV_W;
    contrib   = {{(ACC_W-OUT_W){prodShift[OUT_W-1]}}, prodShift[OUT_W-1:0]};
    accNext   = acc_q + contrib;
    mixShift  = accNext >>> MIX_SHIFT;
    if (mixShift > SAT_MAX) begin
      mixSat  = SAT_MAX[OUT_W-1:0];
      mixClip = 1'b1;
    end else if (mixShift < SAT_MIN) begin
      mixSat  = SAT_MIN[OUT_W-1:0];
      mixClip = 1'b1;
    end else begin
      mixSat  = mixShift[OUT_W-1:0];
      mixClip = 1'b0;
    end
  end

  // The finished mix is registered on the last voice so o_valid lines up with OUTPUT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        step_q[i]  <= '0;
        phase_q[i] <= '0;
        env_q[i]   <= '0;
      end
      gate_q    <= '0;
      wave_q    <= '0;
      atk_q     <= '0;
      rel_q     <= '0;
      voice_q   <= '0;
      acc_q     <= '0;
      audio_q   <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      if (i_step_we) step_q[i_step_addr] <= i_step_data;
      if (i_sample_tick && busy) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (i_sample_tick) begin
            gate_q  <= i_gate;
            wave_q  <= i_wave;
            atk_q   <= i_atk_rate;
            rel_q   <= i_rel_rate;
            voice_q <= '0;
            acc_q   <= '0;
          end
        end
        ACCUM: begin
          env_q[voice_q]   <= envNew;
          phase_q[voice_q] <= phaseNew;
          acc_q            <= accNext;
          voice_q          <= voice_q + 1'b1;
          if (voice_q == LAST_VOICE) begin
            audio_q <= mixSat;
            valid_q <= 1'b1;
            clip_q  <= mixClip;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_audio   = audio_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy;
  assign o_clip    = clip_q;
  assign o_overrun = overrun_q;
endmodule

// File: tb/tb_poly_synth_tdm.sv
// Randomised self-checking bench for poly_synth_tdm, compared against an arithmetic
// model of the voice envelopes, phases and mix.
module tb_poly_synth_tdm;
  localparam int N  = 4;
  localparam int PW = 16;
  localparam int OW = 16;
  localparam int EW = 8;
  localparam int MS = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sampleTick = 1'b0;
  logic [N-1:0]  gate = '0;
  logic [1:0]    wave = '0;
  logic [EW-1:0] atkRate = '0;
  logic [EW-1:0] relRate = '0;
  logic          stepWe = 1'b0;
  logic [1:0]    stepAddr = '0;
  logic [PW-1:0] stepData = '0;
  logic [OW-1:0] audio;
  logic          valid, busy, clip, overrun;

  int compared = 0;
  int mismatched = 0;
  int mEnv [N];
  int mPhase [N];
  int mStep [N];

  poly_synth_tdm #(
    .NUM_VOICES(N), .PHASE_W(PW), .OUT_W(OW), .ENV_W(EW), .MIX_SHIFT(MS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_tick(sampleTick), .i_gate(gate),
    .i_wave(wave), .i_atk_rate(atkRate), .i_rel_rate(relRate),
    .i_step_we(stepWe), .i_step_addr(stepAddr), .i_step_data(stepData),
    .o_audio(audio), .o_valid(valid), .o_busy(busy), .o_clip(clip),
    .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int v = 0; v < N; v++) begin
      mEnv[v] = 0;
      mPhase[v] = 0;
      mStep[v] = 0;
    end
  endtask

  // One output sample from the behavioural rules; also advances the model voice state.
  task automatic modelSample(input logic [N-1:0] g, input int wv, input int atk, input int rel,
                             output int expAudio, output int expClip);
    int acc, p, w, u, c, m, half, full, envMax;
    acc = 0;
    half = 1 << (OW - 1);
    full = 1 << OW;
    envMax = (1 << EW) - 1;
    for (int v = 0; v < N; v++) begin
      if (g[v]) mEnv[v] = (mEnv[v] + atk > envMax) ? envMax : mEnv[v] + atk;
      else      mEnv[v] = (mEnv[v] - rel < 0) ? 0 : mEnv[v] - rel;
      if (!g[v] && mEnv[v] == 0) mPhase[v] = 0;
      else mPhase[v] = (mPhase[v] + mStep[v]) % (1 << PW);
      p = mPhase[v] / (1 << (PW - OW));
      case (wv)
        0: w = p - half;
        1: w = (p < half) ? half - 1 : -(half - 1);
        2: begin
          u = (p < half) ? (2 * p) % full : (2 * (full - 1 - p)) % full;
          w = u - half;
        end
        default: w = 0;
      endcase
      c = (w * mEnv[v]) >>> EW;
      acc += c;
    end
    m = acc >>> MS;
    expClip = 0;
    if (m > half - 1) begin m = half - 1; expClip = 1; end
    else if (m < -half) begin m = -half; expClip = 1; end
    expAudio = m;
  endtask

  task automatic writeStep(input int addr, input logic [PW-1:0] data);
    stepWe = 1'b1;
    stepAddr = 2'(addr);
    stepData = data;
    stepCycle();
    stepWe = 1'b0;
    mStep[addr] = int'(data);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) stepCycle();
    rst = 1'b0;
    modelReset();
  endtask

  // Issues one tick, scrambles inputs while busy, and checks latency, sample and pulse shape.
  task automatic applyStimulus(input logic [N-1:0] g, input logic [1:0] wv, input logic [EW-1:0] atk,
                               input logic [EW-1:0] rel, input bit midWrite, output int seenClip);
    int expA, expC, lat;
    bit seen;
    logic [PW-1:0] newStep;
    gate = g; wave = wv; atkRate = atk; relRate = rel; sampleTick = 1'b1;
    modelSample(g, int'(wv), int'(atk), int'(rel), expA, expC);
    stepCycle();
    sampleTick = 1'b0;
    checkOutput("busyStart", int'(busy), 1);
    newStep = PW'($urandom);
    if (midWrite) begin
      stepWe = 1'b1; stepAddr = 2'd0; stepData = newStep;
    end
    seen = 1'b0; lat = 0; seenClip = 0;
    for (int k = 1; k <= N + 6 && !seen; k++) begin
      stepCycle();
      stepWe = 1'b0;
      gate = N'($urandom); wave = 2'($urandom); atkRate = EW'($urandom); relRate = EW'($urandom);
      if (valid) begin
        seen = 1'b1; lat = k; seenClip = int'(clip);
      end
    end
    checkOutput("latency", lat, N);
    checkOutput("audio", int'($signed(audio)), expA);
    checkOutput("clip", seenClip, expC);
    stepCycle();
    checkOutput("validPulse", int'(valid), 0);
    checkOutput("busyEnd", int'(busy), 0);
    checkOutput("audioHold", int'($signed(audio)), expA);
    if (midWrite) mStep[0] = int'(newStep);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int expA, expB, expC, lat, validSeen, cl;
    modelReset();
    repeat (3) stepCycle();
    rst = 1'b0;
    checkOutput("rstClip", int'(clip), 0);
    checkOutput("rstOverrun", int'(overrun), 0);
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput("idleAudio", int'(audio), 0);
      checkOutput("idleValid", int'(valid), 0);
      checkOutput("idleBusy", int'(busy), 0);
    end

    writeStep(0, 16'h1000);
    applyStimulus(4'b0001, 2'b00, 8'd255, 8'd0, 1'b0, cl);
    checkOutput("sawConst", int'($signed(audio)), -28560);
    applyStimulus(4'b0000, 2'b00, 8'd0, 8'd255, 1'b0, cl);
    checkOutput("releaseConst", int'($signed(audio)), 0);
    for (int v = 0; v < N; v++) writeStep(v, 16'd1);
    applyStimulus(4'b1111, 2'b01, 8'd255, 8'd0, 1'b0, cl);
    checkOutput("squareConst", int'($signed(audio)), 32767);
    checkOutput("squareClip", cl, 1);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) writeStep($urandom_range(0, N - 1), PW'($urandom));
      applyStimulus(N'($urandom), 2'($urandom), EW'($urandom), EW'($urandom),
                    1'($urandom_range(0, 1)), cl);
    end

    // A tick landing in the o_valid cycle is dropped and flagged.
    applyReset();
    writeStep(1, 16'h0300);
    writeStep(2, 16'h0123);
    gate = 4'b0110; wave = 2'b10; atkRate = 8'd90; relRate = 8'd10; sampleTick = 1'b1;
    modelSample(4'b0110, 2, 90, 10, expA, expC);
    stepCycle();
    sampleTick = 1'b0;
    repeat (N) stepCycle();
    checkOutput("ovrAValid", int'(valid), 1);
    checkOutput("ovrAAudio", int'($signed(audio)), expA);
    checkOutput("ovrAFlagBefore", int'(overrun), 0);
    sampleTick = 1'b1;
    stepCycle();
    sampleTick = 1'b0;
    checkOutput("ovrAFlag", int'(overrun), 1);
    checkOutput("ovrABusy", int'(busy), 0);

    // Tick at t+3 is dropped; tick in the cycle after o_valid is accepted.
    applyReset();
    writeStep(0, PW'($urandom));
    writeStep(1, PW'($urandom));
    gate = 4'b0011; wave = 2'b00; atkRate = 8'd200; relRate = 8'd5; sampleTick = 1'b1;
    modelSample(4'b0011, 0, 200, 5, expA, expC);
    stepCycle();
    sampleTick = 1'b0;
    repeat (2) stepCycle();
    sampleTick = 1'b1;
    stepCycle();
    sampleTick = 1'b0;
    checkOutput("ovrBFlag", int'(overrun), 1);
    checkOutput("ovrBBusy", int'(busy), 1);
    stepCycle();
    checkOutput("ovrBValid", int'(valid), 1);
    checkOutput("ovrBAudio", int'($signed(audio)), expA);
    stepCycle();
    checkOutput("ovrBValidLow", int'(valid), 0);
    gate = 4'b0001; wave = 2'b01; atkRate = 8'd40; relRate = 8'd0; sampleTick = 1'b1;
    modelSample(4'b0001, 1, 40, 0, expB, expC);
    stepCycle();
    sampleTick = 1'b0;
    checkOutput("ovrBAccept", int'(busy), 1);
    lat = 0;
    for (int k = 1; k <= N + 4 && lat == 0; k++) begin
      stepCycle();
      if (valid) lat = k;
    end
    checkOutput("ovrBLatency", lat, N);
    checkOutput("ovrBAudio2", int'($signed(audio)), expB);
    checkOutput("ovrBSticky", int'(overrun), 1);

    // Reset in the middle of a computation aborts it without o_valid.
    repeat (2) stepCycle();
    gate = 4'b1111; wave = 2'b00; atkRate = 8'd100; sampleTick = 1'b1;
    stepCycle();
    sampleTick = 1'b0;
    stepCycle();
    rst = 1'b1;
    #2;
    checkOutput("abortAudio", int'(audio), 0);
    checkOutput("abortValid", int'(valid), 0);
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortClip", int'(clip), 0);
    checkOutput("abortOverrun", int'(overrun), 0);
    stepCycle();
    checkOutput("abortBusyHeld", int'(busy), 0);
    stepCycle();
    rst = 1'b0;
    modelReset();
    validSeen = 0;
    for (int k = 0; k < N + 4; k++) begin
      stepCycle();
      if (valid) validSeen++;
    end
    checkOutput("abortNoValid", validSeen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
